// File: rtl/pacman_mover_if.sv
// rtl/pacman_mover_if.sv - pacman_mover control, wall-probe and sprite-state signal bundle
interface pacman_mover_if;
    logic       move_tick;
    logic       dir_valid;
    logic [1:0] dir_req;
    logic [9:0] probe_x;
    logic [8:0] probe_y;
    logic       probe_wall;
    logic [9:0] pos_x;
    logic [8:0] pos_y;
    logic [1:0] cur_dir;
    logic       moving;
    logic       busy;

    modport master (
        output move_tick, dir_valid, dir_req, probe_wall,
        input  probe_x, probe_y, pos_x, pos_y, cur_dir, moving, busy
    );

    modport slave (
        input  move_tick, dir_valid, dir_req, probe_wall,
        output probe_x, probe_y, pos_x, pos_y, cur_dir, moving, busy
    );
endinterface

// File: rtl/pacman_mover.sv
// rtl/pacman_mover.sv - Pac-Man tile-map movement FSM; PACMAN_TURN_BUFFER_EN keeps blocked turns pending
// Probes the leading-edge corners through one wall-map port, then turns, moves straight or stops.
module pacman_mover #(
    parameter int START_X = 16,
    parameter int START_Y = 16
) (
    input  logic           clk,
    input  logic           rst,
    pacman_mover_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, T_A, T_B, C_A, C_B, COMMIT} state_t;

    typedef struct packed {
        logic       oob;
        logic [9:0] x;
        logic [8:0] y;
    } probe_t;

    state_t     state;
    logic [9:0] posX;
    logic [8:0] posY;
    logic [1:0] curDir;
    logic [1:0] pendDir;
    logic       pendValid;
    logic [1:0] turnDir;
    logic       doTurn;
    logic       doMove;
    logic       firstHit;
    logic [9:0] probeX;
    logic [8:0] probeY;
    logic       probeOob;
    logic       moving;
    logic       busy;

    logic       hitNow;
    logic [1:0] stepDir;
    logic [9:0] stepX;
    logic [8:0] stepY;
    logic [1:0] headingNext;
    probe_t     turnProbeA;
    probe_t     turnProbeB;
    probe_t     curProbeA;
    probe_t     curProbeB;

    // Off-map probes count as walls and are clamped so the map never sees an illegal address.
    function automatic probe_t cornerProbe(input logic [1:0] d, input logic second,
                                           input logic [9:0] x, input logic [8:0] y);
        logic signed [11:0] sx;
        logic signed [11:0] sy;
        logic signed [11:0] off;
        probe_t p;
        off = second ? 12'sd15 : 12'sd0;
        sx  = $signed({2'b00, x});
        sy  = $signed({3'b000, y});
        case (d)
            2'd0: begin sx = sx + 12'sd16; sy = sy + off; end
            2'd1: begin sx = sx - 12'sd1;  sy = sy + off; end
            2'd2: begin sy = sy - 12'sd1;  sx = sx + off; end
            2'd3: begin sy = sy + 12'sd16; sx = sx + off; end
        endcase
        p.oob = 1'b0;
        if (sx < 12'sd0) begin
            p.oob = 1'b1;
            p.x   = 10'd0;
        end else if (sx > 12'sd639) begin
            p.oob = 1'b1;
            p.x   = 10'd639;
        end else begin
            p.x = sx[9:0];
        end
        if (sy < 12'sd0) begin
            p.oob = 1'b1;
            p.y   = 9'd0;
        end else if (sy > 12'sd479) begin
            p.oob = 1'b1;
            p.y   = 9'd479;
        end else begin
            p.y = sy[8:0];
        end
        return p;
    endfunction

    assign hitNow     = probeOob || bus.probe_wall;
    assign turnProbeA = cornerProbe(pendDir, 1'b0, posX, posY);
    assign turnProbeB = cornerProbe(turnDir, 1'b1, posX, posY);
    assign curProbeA  = cornerProbe(curDir,  1'b0, posX, posY);
    assign curProbeB  = cornerProbe(curDir,  1'b1, posX, posY);

    always_comb begin
        stepDir = doTurn ? turnDir : curDir;
        stepX   = posX;
        stepY   = posY;
        case (stepDir)
            2'd0: stepX = posX + 10'd1;
            2'd1: stepX = posX - 10'd1;
            2'd2: stepY = posY - 9'd1;
            2'd3: stepY = posY + 9'd1;
        endcase
        headingNext = (state == COMMIT && doTurn) ? turnDir : curDir;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            posX      <= 10'(START_X);
            posY      <= 9'(START_Y);
            curDir    <= 2'd0;
            pendDir   <= 2'd0;
            pendValid <= 1'b0;
            turnDir   <= 2'd0;
            doTurn    <= 1'b0;
            doMove    <= 1'b0;
            firstHit  <= 1'b0;
            probeX    <= 10'(START_X);
            probeY    <= 9'(START_Y);
            probeOob  <= 1'b0;
            moving    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    doTurn <= 1'b0;
                    if (bus.move_tick) begin
                        busy <= 1'b1;
                        if (pendValid) begin
                            state    <= T_A;
                            turnDir  <= pendDir;
                            probeX   <= turnProbeA.x;
                            probeY   <= turnProbeA.y;
                            probeOob <= turnProbeA.oob;
                        end else begin
                            state    <= C_A;
                            probeX   <= curProbeA.x;
                            probeY   <= curProbeA.y;
                            probeOob <= curProbeA.oob;
                        end
                    end
                end
                T_A: begin
                    firstHit <= hitNow;
                    state    <= T_B;
                    probeX   <= turnProbeB.x;
                    probeY   <= turnProbeB.y;
                    probeOob <= turnProbeB.oob;
                end
                T_B: begin
                    if (!firstHit && !hitNow) begin
                        state    <= COMMIT;
                        doTurn   <= 1'b1;
                        doMove   <= 1'b1;
                        probeX   <= posX;
                        probeY   <= posY;
                        probeOob <= 1'b0;
                    end else begin
                        state    <= C_A;
                        doTurn   <= 1'b0;
                        probeX   <= curProbeA.x;
                        probeY   <= curProbeA.y;
                        probeOob <= curProbeA.oob;
                    end
                end
                C_A: begin
                    firstHit <= hitNow;
                    state    <= C_B;
                    probeX   <= curProbeB.x;
                    probeY   <= curProbeB.y;
                    probeOob <= curProbeB.oob;
                end
                C_B: begin
                    state    <= COMMIT;
                    doTurn   <= 1'b0;
                    doMove   <= !firstHit && !hitNow;
                    probeX   <= posX;
                    probeY   <= posY;
                    probeOob <= 1'b0;
                end
                COMMIT: begin
                    if (doMove) begin
                        posX <= stepX;
                        posY <= stepY;
                    end
                    if (doTurn) curDir <= turnDir;
`ifdef PACMAN_TURN_BUFFER_EN
                    if (doTurn) pendValid <= 1'b0;
`else
                    pendValid <= 1'b0;
`endif
                    moving <= doMove;
                    probeX <= doMove ? stepX : posX;
                    probeY <= doMove ? stepY : posY;
                    state  <= IDLE;
                    busy   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // A fresh request wins over any pending clear made at COMMIT this same cycle.
            if (bus.dir_valid) begin
                pendDir   <= bus.dir_req;
                pendValid <= (bus.dir_req != headingNext);
            end
        end
    end

    assign bus.probe_x = probeX;
    assign bus.probe_y = probeY;
    assign bus.pos_x   = posX;
    assign bus.pos_y   = posY;
    assign bus.cur_dir = curDir;
    assign bus.moving  = moving;
    assign bus.busy    = busy;
endmodule

// File: tb/tb_pacman_mover.sv
// tb/tb_pacman_mover.sv - directed self-checking bench for pacman_mover with a bordered tile map
module tb_pacman_mover;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pacman_mover_if bus ();

    pacman_mover #(.START_X(16), .START_Y(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Border tiles plus one wall tile at column 10, row 1.
    function automatic logic isWall(input logic [9:0] x, input logic [8:0] y);
        int col;
        int row;
        col = int'(x) / 16;
        row = int'(y) / 16;
        return (row == 0) || (row == 29) || (col == 0) || (col == 39) || (col == 10 && row == 1);
    endfunction

    assign bus.probe_wall = isWall(bus.probe_x, bus.probe_y);

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulseTick();
        bus.move_tick = 1'b1;
        @(negedge clk);
        bus.move_tick = 1'b0;
    endtask

    task automatic request(input logic [1:0] d);
        bus.dir_valid = 1'b1;
        bus.dir_req   = d;
        @(negedge clk);
        bus.dir_valid = 1'b0;
    endtask

    task automatic edgeSample();
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (bus.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("idle_timeout", 1, 0);
    endtask

    initial begin
        bus.move_tick = 1'b0;
        bus.dir_valid = 1'b0;
        bus.dir_req   = 2'd0;

        // Reset state
        @(negedge clk);
        check("rst_pos_x", bus.pos_x, 16);
        check("rst_pos_y", bus.pos_y, 16);
        check("rst_dir", bus.cur_dir, 0);
        check("rst_moving", bus.moving, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_probe_x", bus.probe_x, 16);
        rst = 1'b0;

        // Open corridor right, with a tick during busy that must be ignored
        @(negedge clk);
        pulseTick();
        check("open_busy_k", bus.busy, 1);
        check("open_probeA_x", bus.probe_x, 32);
        check("open_probeA_y", bus.probe_y, 16);
        edgeSample();
        check("open_probeB_x", bus.probe_x, 32);
        check("open_probeB_y", bus.probe_y, 31);
        @(negedge clk);
        bus.move_tick = 1'b1;
        edgeSample();
        check("open_pos_k2", bus.pos_x, 16);
        @(negedge clk);
        bus.move_tick = 1'b0;
        edgeSample();
        check("open_pos_k3", bus.pos_x, 17);
        check("open_moving", bus.moving, 1);
        check("open_busy_k3", bus.busy, 0);
        repeat (6) edgeSample();
        check("open_extra_tick_ignored", bus.pos_x, 17);

        // Turn down, clear path
        @(negedge clk);
        doReset();
        request(2'd3);
        pulseTick();
        edgeSample();
        edgeSample();
        check("turn_pos_y_k2", bus.pos_y, 16);
        edgeSample();
        check("turn_pos_y_k3", bus.pos_y, 17);
        check("turn_dir", bus.cur_dir, 3);
        check("turn_pos_x", bus.pos_x, 16);

        // Blocked turn up: falls back to moving right at k+5
        @(negedge clk);
        doReset();
        request(2'd2);
        pulseTick();
        check("blk_probeTA_y", bus.probe_y, 15);
        repeat (3) edgeSample();
        check("blk_pos_k3", bus.pos_x, 16);
        check("blk_busy_k3", bus.busy, 1);
        repeat (2) edgeSample();
        check("blk_pos_k5", bus.pos_x, 17);
        check("blk_dir_k5", bus.cur_dir, 0);
        check("blk_moving", bus.moving, 1);
        // Second tick exposes whether the request survived
        @(negedge clk);
        pulseTick();
        repeat (3) edgeSample();
`ifdef PACMAN_TURN_BUFFER_EN
        check("blk2_pos_k3", bus.pos_x, 17);
`else
        check("blk2_pos_k3", bus.pos_x, 18);
`endif
        repeat (2) edgeSample();
        check("blk2_pos_k5", bus.pos_x, 18);

        // Walk right to the wall at column 10, then stop
        @(negedge clk);
        doReset();
        for (int i = 0; i < 128; i++) begin
            pulseTick();
            waitIdle();
        end
        check("walk_pos_x", bus.pos_x, 144);
        request(2'd2);
        pulseTick();
        check("wall_probeTA_x", bus.probe_x, 144);
        check("wall_probeTA_y", bus.probe_y, 15);
        edgeSample();
        edgeSample();
        check("wall_probeCA_x", bus.probe_x, 160);
        edgeSample();
        check("wall_busy_k3", bus.busy, 1);
        repeat (2) edgeSample();
        check("wall_pos_x", bus.pos_x, 144);
        check("wall_pos_y", bus.pos_y, 16);
        check("wall_moving", bus.moving, 0);
        check("wall_busy_k5", bus.busy, 0);

        // Extra tick during busy, then async reset in T_B
        @(negedge clk);
        doReset();
        pulseTick();
        waitIdle();
        check("pre_rst_pos_x", bus.pos_x, 17);
        request(2'd2);
        pulseTick();
        bus.move_tick = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_pos_x", bus.pos_x, 16);
        check("arst_pos_y", bus.pos_y, 16);
        check("arst_moving", bus.moving, 0);
        check("arst_dir", bus.cur_dir, 0);
        check("arst_probe_x", bus.probe_x, 16);
        check("arst_probe_y", bus.probe_y, 16);
        bus.move_tick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) edgeSample();
        check("post_rst_pos_x", bus.pos_x, 16);
        check("post_rst_busy", bus.busy, 0);
        // Pending was discarded: a tick takes the straight path and lands at k+3
        @(negedge clk);
        pulseTick();
        repeat (3) edgeSample();
        check("post_rst_step_k3", bus.pos_x, 17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
